alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_iter.sv | 78 +++++++
 rtl/alu_mc.sv | 180 ++++++++++++++++++
 tb/tb_alu_mc.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, flag bit positions
// and the controller state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_ADC   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_SBC   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_PASSA = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_CLC   = 4'd13;
    localparam logic [3:0] OP_SEC   = 4'd14;
    localparam logic [3:0] OP_NOP   = 4'd15;

    localparam int FLAG_V = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative engine: WIDTH-step shift-add multiply and restoring divide.
// finish pulses one cycle after the last step; hi/lo then hold the answer.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             finish,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt_q;
    logic             div_q;
    logic             finish_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;

    // hi_q is the running accumulator (multiply) or partial remainder (divide);
    // lo_q holds the multiplier / dividend bits as they are consumed.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
        rem_shift = {hi_q, lo_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opa_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            div_q    <= 1'b0;
            finish_q <= 1'b0;
            opa_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            finish_q <= 1'b0;
            if (start) begin
                cnt_q <= CW'(WIDTH);
                div_q <= is_div;
                hi_q  <= '0;
                opa_q <= is_div ? b : a;
                lo_q  <= is_div ? a : b;
            end else if (cnt_q != '0) begin
                cnt_q    <= cnt_q - CW'(1);
                finish_q <= (cnt_q == CW'(1));
                if (div_q) begin
                    // A zero divisor always "fits", giving all-ones quotient and remainder = a.
                    if (rem_shift >= {1'b0, opa_q}) begin
                        hi_q <= rem_diff[WIDTH-1:0];
                        lo_q <= {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_q <= rem_shift[WIDTH-1:0];
                        lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    {hi_q, lo_q} <= {mul_sum, lo_q[WIDTH-1:1]};
                end
            end
        end
    end

    assign finish = finish_q;
    assign hi     = hi_q;
    assign lo     = lo_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU controller: single-cycle ops and all flag logic live here.
// state | meaning: IDLE wait for start | EXEC one-cycle op | ITER mul/div running | DONE result valid
module alu_mc
    import alu_pkg::*;
#(
    parameter int         WIDTH     = 8,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags
);

    localparam int MSB = WIDTH - 1;

    state_t           state_q, state_d;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] res_q, hi_q;
    logic [3:0]       flg_q;
    logic [WIDTH-1:0] nres, nhi;
    logic [3:0]       nflg;
    logic             accept;
    logic             iter_start;
    logic             iter_finish;
    logic [WIDTH-1:0] iter_hi, iter_lo;
    logic             add_cin, sub_cin;
    logic [WIDTH:0]   add_sum, sub_dif;
    logic             commit;

    assign accept     = (state_q == ST_IDLE) && start;
    assign iter_start = accept && is_iter_op(op);

    alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (iter_start),
        .is_div (op == OP_DIVU),
        .a      (a),
        .b      (b),
        .finish (iter_finish),
        .hi     (iter_hi),
        .lo     (iter_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = is_iter_op(op) ? ST_ITER : ST_EXEC;
            ST_EXEC: begin
                state_d = ST_DONE;
                commit  = 1'b1;
            end
            ST_ITER: if (iter_finish) begin
                state_d = ST_DONE;
                commit  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_EXEC) || (state_q == ST_ITER);
    assign done = (state_q == ST_DONE);

    always_comb begin
        nres    = res_q;
        nhi     = hi_q;
        nflg    = flg_q;
        add_cin = (op_q == OP_ADC) && flg_q[FLAG_C];
        sub_cin = (op_q == OP_SBC) && flg_q[FLAG_C];
        add_sum = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, add_cin};
        sub_dif = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, sub_cin};
        case (op_q)
            OP_ADD, OP_ADC: begin
                nres         = add_sum[MSB:0];
                nhi          = '0;
                nflg[FLAG_C] = add_sum[WIDTH];
                nflg[FLAG_V] = (a_q[MSB] == b_q[MSB]) && (add_sum[MSB] != a_q[MSB]);
            end
            OP_SUB, OP_SBC: begin
                // Bit WIDTH of the extended difference is the borrow.
                nres         = sub_dif[MSB:0];
                nhi          = '0;
                nflg[FLAG_C] = sub_dif[WIDTH];
                nflg[FLAG_V] = (a_q[MSB] != b_q[MSB]) && (sub_dif[MSB] != a_q[MSB]);
            end
            OP_AND, OP_OR, OP_XOR: begin
                nres         = (op_q == OP_AND) ? (a_q & b_q) :
                               (op_q == OP_OR)  ? (a_q | b_q) : (a_q ^ b_q);
                nhi          = '0;
                nflg[FLAG_C] = 1'b0;
                nflg[FLAG_V] = 1'b0;
            end
            OP_SHR: begin
                nres         = {flg_q[FLAG_C], a_q[MSB:1]};
                nhi          = '0;
                nflg[FLAG_C] = a_q[0];
                nflg[FLAG_V] = a_q[MSB] ^ nres[MSB];
            end
            OP_SHL: begin
                nres         = {a_q[MSB-1:0], flg_q[FLAG_C]};
                nhi          = '0;
                nflg[FLAG_C] = a_q[MSB];
                nflg[FLAG_V] = a_q[MSB] ^ nres[MSB];
            end
            OP_PASSA: begin
                nres = a_q;
                nhi  = '0;
            end
            OP_PASSB: begin
                nres = b_q;
                nhi  = '0;
            end
            OP_MUL: begin
                nres         = iter_lo;
                nhi          = iter_hi;
                nflg[FLAG_Z] = (iter_hi == '0) && (iter_lo == '0);
                nflg[FLAG_N] = iter_hi[MSB];
                nflg[FLAG_C] = (iter_hi != '0);
                nflg[FLAG_V] = 1'b0;
            end
            OP_DIVU: begin
                nres         = iter_lo;
                nhi          = iter_hi;
                nflg[FLAG_Z] = (iter_lo == '0);
                nflg[FLAG_N] = 1'b0;
                nflg[FLAG_C] = 1'b0;
                nflg[FLAG_V] = (b_q == '0);
            end
            OP_CLC:  nflg[FLAG_C] = 1'b0;
            OP_SEC:  nflg[FLAG_C] = 1'b1;
            default: ;
        endcase
        if (op_q <= OP_SHL) begin
            nflg[FLAG_Z] = (nres == '0);
            nflg[FLAG_N] = nres[MSB];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q  <= OP_ADD;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            hi_q  <= '0;
            flg_q <= FLAGS_RST;
        end else begin
            if (accept) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
            end
            if (commit) begin
                res_q <= nres;
                hi_q  <= nhi;
                flg_q <= nflg;
            end
        end
    end

    assign result    = res_q;
    assign result_hi = hi_q;
    assign flags     = flg_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed corner cases, then random ops against an
// arithmetic reference model of the op-code rules.
module tb_alu_mc;

    localparam int         W  = 8;
    localparam logic [3:0] FR = 4'b1010;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] result, result_hi;
    logic [3:0]   flags;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_res, m_hi;
    logic [3:0]   m_flg;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W), .FLAGS_RST(FR)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: flags are {V,N,Z,C}; values computed as plain integers.
    task automatic model(input int o, input int x, input int y);
        int r, hi, p, cin, c;
        logic [3:0] f;
        f  = m_flg;
        c  = int'(m_flg[0]);
        r  = int'(m_res);
        hi = int'(m_hi);
        case (o)
            0, 1: begin
                cin  = (o == 1) ? c : 0;
                p    = x + y + cin;
                r    = p % 256;
                hi   = 0;
                f[0] = (p > 255);
                f[3] = ((x >= 128) == (y >= 128)) && ((r >= 128) != (x >= 128));
            end
            2, 3: begin
                cin  = (o == 3) ? c : 0;
                r    = (x - y - cin + 256) % 256;
                hi   = 0;
                f[0] = (x < y + cin);
                f[3] = ((x >= 128) != (y >= 128)) && ((r >= 128) != (x >= 128));
            end
            4, 5, 6: begin
                r    = (o == 4) ? (x & y) : (o == 5) ? (x | y) : (x ^ y);
                hi   = 0;
                f[0] = 1'b0;
                f[3] = 1'b0;
            end
            7: begin
                r    = c * 128 + x / 2;
                hi   = 0;
                f[0] = (x % 2 == 1);
                f[3] = ((x >= 128) != (r >= 128));
            end
            8: begin
                r    = (x * 2) % 256 + c;
                hi   = 0;
                f[0] = (x >= 128);
                f[3] = ((x >= 128) != (r >= 128));
            end
            9:  begin r = x; hi = 0; end
            10: begin r = y; hi = 0; end
            11: begin
                p    = x * y;
                r    = p % 256;
                hi   = p / 256;
                f[1] = (p == 0);
                f[2] = (hi >= 128);
                f[0] = (hi != 0);
                f[3] = 1'b0;
            end
            12: begin
                if (y == 0) begin
                    r    = 255;
                    hi   = x;
                    f[3] = 1'b1;
                end else begin
                    r    = x / y;
                    hi   = x % y;
                    f[3] = 1'b0;
                end
                f[1] = (r == 0);
                f[2] = 1'b0;
                f[0] = 1'b0;
            end
            13: f[0] = 1'b0;
            14: f[0] = 1'b1;
            default: ;
        endcase
        if (o <= 8) begin
            f[1] = (r == 0);
            f[2] = (r >= 128);
        end
        m_res = W'(r);
        m_hi  = W'(hi);
        m_flg = f;
    endtask

    task automatic run_op(input string tag, input int o, input int x, input int y);
        int lat, busy_n, exp_lat;
        exp_lat = (o == 11 || o == 12) ? W + 2 : 2;
        @(negedge clk);
        start = 1'b1;
        op    = 4'(o);
        a     = W'(x);
        b     = W'(y);
        model(o, x, y);
        @(negedge clk);
        start  = 1'b0;
        lat    = 1;
        busy_n = 0;
        while (!done && lat < 40) begin
            busy_n += int'(busy);
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy_cycles"}, busy_n, exp_lat - 1);
        check({tag, " result"}, result, m_res);
        check({tag, " result_hi"}, result_hi, m_hi);
        check({tag, " flags"}, flags, m_flg);
        @(negedge clk);
        check({tag, " done_pulse"}, done, 0);
        check({tag, " result_hold"}, result, m_res);
    endtask

    initial begin
        int lat, dones, busys;
        int o, x, y;
        m_res = '0;
        m_hi  = '0;
        m_flg = FR;

        // Reset with start held high: reset must win.
        reset = 1'b1;
        start = 1'b1;
        op    = 4'd0;
        a     = 8'h01;
        b     = 8'h01;
        repeat (3) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst result", result, 0);
        check("rst result_hi", result_hi, 0);
        check("rst flags", flags, FR);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst busy", busy, 0);

        run_op("add_ovf", 0, 8'h7F, 8'h01);
        check("add_ovf const_res", result, 8'h80);
        check("add_ovf const_flags", flags, 4'b1100);

        run_op("sub_borrow", 2, 8'h00, 8'h01);
        check("sub_borrow const_res", result, 8'hFF);
        check("sub_borrow const_flags", flags, 4'b0101);
        run_op("sbc", 3, 8'h05, 8'h02);
        check("sbc const_res", result, 8'h02);

        run_op("mul_ff", 11, 8'hFF, 8'hFF);
        check("mul_ff const_res", result, 8'h01);
        check("mul_ff const_hi", result_hi, 8'hFE);
        check("mul_ff const_c", flags[0], 1);

        run_op("divu", 12, 8'h64, 8'h07);
        check("divu const_res", result, 8'h0E);
        check("divu const_hi", result_hi, 8'h02);
        run_op("divu_zero", 12, 8'h10, 8'h00);
        check("divu_zero const_res", result, 8'hFF);
        check("divu_zero const_hi", result_hi, 8'h10);
        check("divu_zero const_v", flags[3], 1);

        run_op("sec", 14, 8'h00, 8'h00);
        run_op("shr", 7, 8'h02, 8'h00);
        check("shr const_res", result, 8'h81);
        check("shr const_c", flags[0], 0);
        run_op("nop", 15, 8'h33, 8'h44);

        // MUL with a start while busy and another in the DONE cycle: both ignored.
        @(negedge clk);
        start = 1'b1;
        op    = 4'd11;
        a     = 8'h12;
        b     = 8'h34;
        model(11, 8'h12, 8'h34);
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            start = (lat == 3);
            op    = 4'd0;
            a     = 8'h01;
            b     = 8'h01;
            @(negedge clk);
            lat++;
        end
        start = 1'b1;
        check("mul_ign latency", lat, W + 2);
        check("mul_ign result", result, m_res);
        check("mul_ign result_hi", result_hi, m_hi);
        check("mul_ign flags", flags, m_flg);
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        busys = 0;
        repeat (12) begin
            @(negedge clk);
            dones += int'(done);
            busys += int'(busy);
        end
        check("mul_ign extra_done", dones, 0);
        check("mul_ign extra_busy", busys, 0);

        // Reset in the middle of a MUL aborts it.
        @(negedge clk);
        start = 1'b1;
        op    = 4'd11;
        a     = 8'hAB;
        b     = 8'hCD;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_res = '0;
        m_hi  = '0;
        m_flg = FR;
        check("mid_rst busy", busy, 0);
        check("mid_rst done", done, 0);
        check("mid_rst flags", flags, FR);
        check("mid_rst result", result, 0);
        check("mid_rst result_hi", result_hi, 0);
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            dones += int'(done);
        end
        check("mid_rst no_done", dones, 0);

        for (int i = 0; i < 80; i++) begin
            o = int'($urandom_range(0, 15));
            x = int'($urandom_range(0, 255));
            y = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            run_op($sformatf("rnd%0d_op%0d", i, o), o, x, y);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
